// File: rtl/ddr_arb_pkg.sv
// Shared types for the DDR AXI write-port arbiter: AW request bundle, ID tag widths
// and the burst FSM states.
package ddr_arb_pkg;

    localparam int TAG_W    = 4;
    localparam int REQ_ID_W = 12;
    localparam int DDR_ID_W = TAG_W + REQ_ID_W;

    typedef struct packed {
        logic [REQ_ID_W-1:0] id;
        logic [63:0]         addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } aw_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW_ISSUE,
        ST_W_XFER
    } arb_state_e;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping
// modulo NUM_REQ. Returns a one-hot grant, its index and a valid flag.
module rr_arb #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    int   j;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/ddr_axi_wr_arb.sv
// Round-robin share of one 512-bit DDR AXI4 write port; AWID tagged with requester
// index, B routed back by tag, per-requester outstanding-write limit.
//   state       | meaning
//   ST_IDLE     | arbitrate among eligible requesters, pulse m_awready to the winner
//   ST_AW_ISSUE | present registered AW to DDR until accepted
//   ST_W_XFER   | W channel passes through from the winner until the wlast beat
module ddr_axi_wr_arb
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_OUTS = 8
) (
    input  logic                   clk_core,
    input  logic                   rst,
    input  logic [NUM_REQ*12-1:0]  m_awid,
    input  logic [NUM_REQ*64-1:0]  m_awaddr,
    input  logic [NUM_REQ*8-1:0]   m_awlen,
    input  logic [NUM_REQ*3-1:0]   m_awsize,
    input  logic [NUM_REQ*2-1:0]   m_awburst,
    input  logic [NUM_REQ-1:0]     m_awvalid,
    output logic [NUM_REQ-1:0]     m_awready,
    input  logic [NUM_REQ*512-1:0] m_wdata,
    input  logic [NUM_REQ*64-1:0]  m_wstrb,
    input  logic [NUM_REQ-1:0]     m_wlast,
    input  logic [NUM_REQ-1:0]     m_wvalid,
    output logic [NUM_REQ-1:0]     m_wready,
    output logic [11:0]            m_bid,
    output logic [1:0]             m_bresp,
    output logic [NUM_REQ-1:0]     m_bvalid,
    input  logic [NUM_REQ-1:0]     m_bready,
    output logic [15:0]            cl_sh_ddr_awid,
    output logic [63:0]            cl_sh_ddr_awaddr,
    output logic [7:0]             cl_sh_ddr_awlen,
    output logic [2:0]             cl_sh_ddr_awsize,
    output logic [1:0]             cl_sh_ddr_awburst,
    output logic                   cl_sh_ddr_awvalid,
    input  logic                   sh_cl_ddr_awready,
    output logic [15:0]            cl_sh_ddr_wid,
    output logic [511:0]           cl_sh_ddr_wdata,
    output logic [63:0]            cl_sh_ddr_wstrb,
    output logic                   cl_sh_ddr_wlast,
    output logic                   cl_sh_ddr_wvalid,
    input  logic                   sh_cl_ddr_wready,
    input  logic [15:0]            sh_cl_ddr_bid,
    input  logic [1:0]             sh_cl_ddr_bresp,
    input  logic                   sh_cl_ddr_bvalid,
    output logic                   cl_sh_ddr_bready
);

    localparam int         IDX_W   = $clog2(NUM_REQ);
    localparam logic [7:0] CNT_MAX = 8'(MAX_OUTS);

    arb_state_e          st_q, st_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    aw_req_t             aw_q, aw_d;
    logic [7:0]          outs_cnt_q [NUM_REQ];
    logic [7:0]          outs_cnt_d [NUM_REQ];

    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_vld;
    logic [NUM_REQ-1:0]  aw_inc;
    logic [NUM_REQ-1:0]  b_dec;
    logic [TAG_W-1:0]    b_tag;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = m_awvalid[i] && (outs_cnt_q[i] != CNT_MAX);
        end
    end

    rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
        .req_i (elig),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_comb begin
        st_d      = st_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        aw_d      = aw_q;
        m_awready = '0;
        unique case (st_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    m_awready  = arb_gnt;
                    gnt_idx_d  = arb_idx;
                    aw_d.id    = m_awid[REQ_ID_W*arb_idx +: REQ_ID_W];
                    aw_d.addr  = m_awaddr[64*arb_idx +: 64];
                    aw_d.len   = m_awlen[8*arb_idx +: 8];
                    aw_d.size  = m_awsize[3*arb_idx +: 3];
                    aw_d.burst = m_awburst[2*arb_idx +: 2];
                    rr_ptr_d   = (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
                    st_d       = ST_AW_ISSUE;
                end
            end
            ST_AW_ISSUE: begin
                if (sh_cl_ddr_awready) st_d = ST_W_XFER;
            end
            ST_W_XFER: begin
                // AWLEN is not counted; the requester's wlast alone ends the burst.
                if (m_wvalid[gnt_idx_q] && sh_cl_ddr_wready && m_wlast[gnt_idx_q]) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (rst) begin
            st_q      <= ST_IDLE;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            aw_q      <= '0;
        end else begin
            st_q      <= st_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            aw_q      <= aw_d;
        end
    end

    assign cl_sh_ddr_awvalid = (st_q == ST_AW_ISSUE);
    assign cl_sh_ddr_awid    = {TAG_W'(gnt_idx_q), aw_q.id};
    assign cl_sh_ddr_wid     = cl_sh_ddr_awid;
    assign cl_sh_ddr_awaddr  = aw_q.addr;
    assign cl_sh_ddr_awlen   = aw_q.len;
    assign cl_sh_ddr_awsize  = aw_q.size;
    assign cl_sh_ddr_awburst = aw_q.burst;

    always_comb begin
        cl_sh_ddr_wdata  = '0;
        cl_sh_ddr_wstrb  = '0;
        cl_sh_ddr_wlast  = 1'b0;
        cl_sh_ddr_wvalid = 1'b0;
        m_wready         = '0;
        if (st_q == ST_W_XFER) begin
            cl_sh_ddr_wdata        = m_wdata[512*gnt_idx_q +: 512];
            cl_sh_ddr_wstrb        = m_wstrb[64*gnt_idx_q +: 64];
            cl_sh_ddr_wlast        = m_wlast[gnt_idx_q];
            cl_sh_ddr_wvalid       = m_wvalid[gnt_idx_q];
            m_wready[gnt_idx_q]    = sh_cl_ddr_wready;
        end
    end

    // Tags with no matching requester fall through with bready=1 so they drain.
    assign b_tag   = sh_cl_ddr_bid[15:12];
    assign m_bid   = sh_cl_ddr_bid[11:0];
    assign m_bresp = sh_cl_ddr_bresp;

    always_comb begin
        m_bvalid         = '0;
        cl_sh_ddr_bready = 1'b1;
        b_dec            = '0;
        aw_inc           = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (b_tag == TAG_W'(i)) begin
                m_bvalid[i]      = sh_cl_ddr_bvalid;
                cl_sh_ddr_bready = m_bready[i];
                b_dec[i]         = sh_cl_ddr_bvalid && m_bready[i];
            end
            aw_inc[i] = (st_q == ST_AW_ISSUE) && sh_cl_ddr_awready && (gnt_idx_q == IDX_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            outs_cnt_d[i] = outs_cnt_q[i];
            if (aw_inc[i] && !b_dec[i]) begin
                outs_cnt_d[i] = outs_cnt_q[i] + 8'd1;
            end else if (b_dec[i] && !aw_inc[i] && (outs_cnt_q[i] != 8'd0)) begin
                outs_cnt_d[i] = outs_cnt_q[i] - 8'd1;
            end
        end
    end

    always_ff @(posedge clk_core) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) outs_cnt_q[i] <= '0;
            else     outs_cnt_q[i] <= outs_cnt_d[i];
        end
    end

    // A B with no write outstanding for its tag means the slave or a requester misbehaved.
    always_ff @(posedge clk_core) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                assert (!(b_dec[i] && !aw_inc[i] && (outs_cnt_q[i] == 8'd0)));
            end
        end
    end

endmodule
